// File: rtl/recv_ctrl_pkg.sv
// Shared types for the UART receive controller: FSM states, read-mode encoding
// and the default FIFO depth.
package recv_ctrl_pkg;

    localparam int DEPTH_DEFAULT = 1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic {
        MODE_BYTE = 1'b0,
        MODE_WORD = 1'b1
    } mode_e;

    // Byte index of the final capture for a read of the given mode.
    function automatic logic [1:0] last_index(input mode_e mode);
        logic [1:0] idx;
        case (mode)
            MODE_WORD: idx = 2'd3;
            MODE_BYTE: idx = 2'd0;
            default:   idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/recv_ctrl.sv
// Receive controller: pushes UART bytes into an external FIFO, tracks its
// occupancy, and serves byte/word reads to the core from the FIFO head.
module recv_ctrl
    import recv_ctrl_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  fifo_indata,
    output logic        fifo_push,
    output logic        fifo_pop,
    input  logic [7:0]  fifo_outdata,
    input  logic        fifo_empty,
    input  logic        req,
    input  logic        req_word,
    input  logic        abort,
    output logic [31:0] rdata,
    output logic        done,
    output logic        busy,
    output logic        full,
    output logic        overflow,
    input  logic        clr_ovf
);

    localparam int            CW         = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH - 1);

    state_e        state_q, state_d;
    mode_e         mode_q, mode_d;
    logic [1:0]    idx_q, idx_d;
    logic [23:0]   lanes_q, lanes_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [CW-1:0] occ_q, occ_d;
    logic          ovf_q, ovf_d;
    logic          take_s, last_s, full_s, push_s, drop_s;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a byte then.
    assign take_s = (state_q == ST_WAIT) && !fifo_empty && !abort;
    assign last_s = (idx_q == last_index(mode_q));
    assign full_s = (occ_q == FULL_LEVEL);
    assign push_s = rstn && rx_valid && (!full_s || take_s);
    assign drop_s = rx_valid && full_s && !take_s;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req) state_d = ST_WAIT;
                else     state_d = ST_IDLE;
            end
            ST_WAIT: begin
                if (abort)                 state_d = ST_IDLE;
                else if (take_s && last_s) state_d = ST_DONE;
                else                       state_d = ST_WAIT;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Read datapath: mode latch, byte lanes and result capture on the last byte.
    always_comb begin
        mode_d  = mode_q;
        idx_d   = idx_q;
        lanes_d = lanes_q;
        rdata_d = rdata_q;
        if ((state_q == ST_IDLE) && req) begin
            mode_d = mode_e'(req_word);
            idx_d  = 2'd0;
        end else if (take_s) begin
            idx_d = idx_q + 2'd1;
            case (idx_q)
                2'd0:    lanes_d[7:0]   = fifo_outdata;
                2'd1:    lanes_d[15:8]  = fifo_outdata;
                2'd2:    lanes_d[23:16] = fifo_outdata;
                default: lanes_d        = lanes_q;
            endcase
            if (last_s) begin
                if (mode_q == MODE_WORD) rdata_d = {fifo_outdata, lanes_q};
                else                     rdata_d = {24'd0, fifo_outdata};
            end else begin
                rdata_d = rdata_q;
            end
        end else begin
            idx_d = idx_q;
        end
    end

    // Occupancy and sticky overflow next-state; a drop beats a clear.
    always_comb begin
        occ_d = occ_q;
        ovf_d = ovf_q;
        if (push_s && !take_s)      occ_d = occ_q + CW'(1);
        else if (!push_s && take_s) occ_d = occ_q - CW'(1);
        else                        occ_d = occ_q;
        if (drop_s)       ovf_d = 1'b1;
        else if (clr_ovf) ovf_d = 1'b0;
        else              ovf_d = ovf_q;
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode_q  <= MODE_BYTE;
            idx_q   <= 2'd0;
            lanes_q <= 24'd0;
            rdata_q <= 32'd0;
            occ_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            lanes_q <= lanes_d;
            rdata_q <= rdata_d;
            occ_q   <= occ_d;
            ovf_q   <= ovf_d;
        end
    end

    // Output decode.
    always_comb begin
        fifo_indata = rx_data;
        fifo_push   = push_s;
        fifo_pop    = take_s;
        rdata       = rdata_q;
        done        = (state_q == ST_DONE);
        busy        = (state_q != ST_IDLE);
        full        = full_s;
        overflow    = ovf_q;
    end

endmodule

// File: tb/tb_recv_ctrl.sv
// Self-checking bench for recv_ctrl: a behavioural FIFO answers the DUT's
// strobes while an expected-byte queue predicts strobes, results and flags.
module tb_recv_ctrl;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  fifo_indata;
    logic        fifo_push;
    logic        fifo_pop;
    logic [7:0]  fifo_outdata;
    logic        fifo_empty;
    logic        req;
    logic        req_word;
    logic        abort;
    logic [31:0] rdata;
    logic        done;
    logic        busy;
    logic        full;
    logic        overflow;
    logic        clr_ovf;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  exp_q[$];
    logic        exp_ovf   = 1'b0;
    logic [31:0] exp_rdata = 32'd0;

    logic [7:0]  mem [0:DEPTH-1];
    int          rd_p, wr_p, cnt;

    recv_ctrl #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .fifo_indata  (fifo_indata),
        .fifo_push    (fifo_push),
        .fifo_pop     (fifo_pop),
        .fifo_outdata (fifo_outdata),
        .fifo_empty   (fifo_empty),
        .req          (req),
        .req_word     (req_word),
        .abort        (abort),
        .rdata        (rdata),
        .done         (done),
        .busy         (busy),
        .full         (full),
        .overflow     (overflow),
        .clr_ovf      (clr_ovf)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO sitting beside the controller, sharing its reset.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_p <= 0;
            wr_p <= 0;
            cnt  <= 0;
        end else begin
            if (fifo_push) begin
                mem[wr_p] <= fifo_indata;
                wr_p      <= (wr_p + 1) % DEPTH;
            end
            if (fifo_pop) rd_p <= (rd_p + 1) % DEPTH;
            cnt <= cnt + (fifo_push ? 1 : 0) - (fifo_pop ? 1 : 0);
        end
    end

    assign fifo_empty   = (cnt == 0);
    assign fifo_outdata = mem[rd_p];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_exp_full(input string tag);
        chk(tag, 32'(full), 32'(exp_q.size() == DEPTH - 1));
    endtask

    // One idle cycle with all quiet flags checked.
    task automatic idle_check(input string tag);
        @(negedge clk);
        chk({tag, "_ovf"},  32'(overflow), 32'(exp_ovf));
        chk_exp_full({tag, "_full"});
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_pop"},  32'(fifo_pop), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit clr);
        bit pushd;
        rx_valid = 1'b1;
        rx_data  = b;
        clr_ovf  = clr;
        @(negedge clk);
        chk("push_ovf_state", 32'(overflow), 32'(exp_ovf));
        chk_exp_full("push_full_state");
        pushd = (exp_q.size() < DEPTH - 1);
        chk("push_strobe", 32'(fifo_push), 32'(pushd));
        chk("push_data", 32'(fifo_indata), 32'(b));
        if (!pushd)   exp_ovf = 1'b1;
        else if (clr) exp_ovf = 1'b0;
        if (pushd) exp_q.push_back(b);
        @(posedge clk); #1;
        rx_valid = 1'b0;
        clr_ovf  = 1'b0;
    endtask

    task automatic clr_cycle();
        clr_ovf = 1'b1;
        @(posedge clk); #1;
        clr_ovf = 1'b0;
        exp_ovf = 1'b0;
    endtask

    // A core read: one pop per waiting cycle while bytes are queued; done follows the last pop.
    task automatic do_read(input bit word, input int push_prob, input int abort_at,
                           input int push_at, input logic [7:0] push_val, input int exp_lat);
        int          need;
        int          got;
        int          cyc;
        bit          popd;
        bit          pushd;
        bit          ended;
        logic [31:0] asm;
        need  = word ? 4 : 1;
        got   = 0;
        cyc   = 0;
        ended = 1'b0;
        asm   = 32'd0;
        req      = 1'b1;
        req_word = word;
        abort    = 1'($urandom_range(1));
        rx_valid = 1'b0;
        @(negedge clk);
        chk("req_busy", 32'(busy), 32'd0);
        chk("req_pop", 32'(fifo_pop), 32'd0);
        @(posedge clk); #1;
        req   = 1'b0;
        abort = 1'b0;
        while (!ended) begin
            cyc++;
            abort    = (cyc == abort_at);
            rx_valid = (cyc == push_at) || ($urandom_range(99) < push_prob);
            rx_data  = (cyc == push_at) ? push_val : 8'($urandom);
            @(negedge clk);
            popd  = (exp_q.size() > 0) && !abort;
            pushd = rx_valid && ((exp_q.size() < DEPTH - 1) || popd);
            chk("wait_busy", 32'(busy), 32'd1);
            chk("wait_done", 32'(done), 32'd0);
            chk("wait_pop", 32'(fifo_pop), 32'(popd));
            chk("wait_push", 32'(fifo_push), 32'(pushd));
            if (popd) begin
                asm[8*got +: 8] = exp_q.pop_front();
                got++;
            end
            if (pushd) exp_q.push_back(rx_data);
            if (rx_valid && !pushd) exp_ovf = 1'b1;
            @(posedge clk); #1;
            rx_valid = 1'b0;
            abort    = 1'b0;
            if (cyc == abort_at) begin
                ended = 1'b1;
                @(negedge clk);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                chk("abort_rdata", rdata, exp_rdata);
                @(posedge clk); #1;
            end else if (got == need) begin
                ended     = 1'b1;
                exp_rdata = asm;
                abort     = 1'($urandom_range(1));
                @(negedge clk);
                chk("done_pulse", 32'(done), 32'd1);
                chk("done_busy", 32'(busy), 32'd1);
                chk("done_pop", 32'(fifo_pop), 32'd0);
                chk("done_rdata", rdata, exp_rdata);
                if (exp_lat > 0) chk("latency", 32'(cyc + 1), 32'(exp_lat));
                @(posedge clk); #1;
                abort = 1'b0;
                @(negedge clk);
                chk("after_done", 32'(done), 32'd0);
                chk("after_busy", 32'(busy), 32'd0);
                chk("after_rdata", rdata, exp_rdata);
                @(posedge clk); #1;
            end else if (cyc >= 300) begin
                ended = 1'b1;
                checks++;
                failures++;
                $error("FAIL read_timeout observed=%0d cycles expected=done", cyc);
            end
        end
        chk("occupancy", 32'(dut.occ_q), 32'(exp_q.size()));
    endtask

    initial begin
        rstn     = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b1;
        req      = 1'b0;
        req_word = 1'b0;
        abort    = 1'b0;
        clr_ovf  = 1'b0;
        #3;
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_push", 32'(fifo_push), 32'd0);
        chk("rst_pop", 32'(fifo_pop), 32'd0);
        rx_valid = 1'b0;
        #19 rstn = 1'b1;
        @(posedge clk); #1;

        // Fill to capacity, then drop, drop-with-clear, clear.
        for (int i = 0; i < DEPTH - 2; i++) push_byte(8'(i), 1'b0);
        idle_check("below_full");
        push_byte(8'hFE, 1'b0);
        idle_check("at_full");
        chk("full_flag", 32'(full), 32'd1);
        push_byte(8'hEE, 1'b0);
        idle_check("drop");
        chk("ovf_set", 32'(overflow), 32'd1);
        push_byte(8'hED, 1'b1);
        idle_check("drop_wins_clr");
        clr_cycle();
        idle_check("clr");
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Push and pop together while full.
        do_read(1'b0, 0, -1, 1, 8'h5C, 2);
        chk("full_pushpop_occ", 32'(dut.occ_q), 32'(DEPTH - 1));
        idle_check("full_pushpop");
        push_byte(8'h77, 1'b0);
        idle_check("drop_again");

        // Asynchronous reset in the middle of a word read.
        req      = 1'b1;
        req_word = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        rx_valid = 1'b1;
        #2 rstn = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_rdata", rdata, 32'd0);
        chk("arst_full", 32'(full), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        chk("arst_pop", 32'(fifo_pop), 32'd0);
        chk("arst_push", 32'(fifo_push), 32'd0);
        chk("arst_occ", 32'(dut.occ_q), 32'd0);
        exp_q.delete();
        exp_ovf   = 1'b0;
        exp_rdata = 32'd0;
        @(negedge clk);
        rx_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("arst_hold_done", 32'(done), 32'd0);
        #2 rstn = 1'b1;
        @(posedge clk); #1;

        // Little-endian word read with data present.
        push_byte(8'h11, 1'b0);
        push_byte(8'h22, 1'b0);
        push_byte(8'h33, 1'b0);
        push_byte(8'h44, 1'b0);
        do_read(1'b1, 0, -1, -1, 8'h00, 5);
        chk("word_rdata", rdata, 32'h4433_2211);

        // Byte read stalls on an empty FIFO until a byte arrives.
        do_read(1'b0, 0, -1, 10, 8'hA5, 0);
        chk("byte_rdata", rdata, 32'h0000_00A5);

        // Abort a word read that has only two bytes.
        push_byte(8'h01, 1'b0);
        push_byte(8'h02, 1'b0);
        do_read(1'b1, 0, 4, -1, 8'h00, 0);
        chk("abort_keeps_rdata", rdata, 32'h0000_00A5);

        // Randomized reads with background traffic and occasional aborts.
        for (int n = 0; n < 40; n++) begin
            int k;
            int ab;
            k  = int'($urandom_range(5));
            ab = ($urandom_range(7) == 0) ? int'($urandom_range(1, 3)) : -1;
            for (int j = 0; j < k; j++) push_byte(8'($urandom), 1'b0);
            do_read(1'($urandom_range(1)), 30, ab, -1, 8'h00, 0);
        end
        idle_check("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
